// File: rtl/x_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : x_ctrl_fsm_if
//  Description : Bundle between the x_ctrl_fsm controller and its neighbours:
//                instruction fetch handshake (instr_valid/instr_ready/instr),
//                datapath status (zero, mem_ack) and the control selects and
//                strobes driven to X, the register file, data memory and PC.
//                master : controller side (drives the selects and strobes)
//                slave  : fetch/datapath side (drives instruction and status)
//  Revision    : 1.0 - initial release
// ============================================================================
interface x_ctrl_fsm_if;
   // fetch handshake
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   // datapath status
   logic        zero;
   logic        mem_ack;
   // execute-stage selects
   logic [1:0]  alu_op;
   logic        reg_dst;
   logic        alu_src;
   // strobes
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        pc_write;
   logic        pc_src;
   logic        illegal;
   // performance counter
   logic [31:0] retired_count;

   modport master (
      input  instr_valid, instr, zero, mem_ack,
      output instr_ready, alu_op, reg_dst, alu_src, reg_write, mem_read,
             mem_write, pc_write, pc_src, illegal, retired_count
   );

   modport slave (
      output instr_valid, instr, zero, mem_ack,
      input  instr_ready, alu_op, reg_dst, alu_src, reg_write, mem_read,
             mem_write, pc_write, pc_src, illegal, retired_count
   );
endinterface
`default_nettype wire

// File: rtl/x_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : x_ctrl_fsm
//  Description : Multi-cycle control FSM sequencing the X execute stage for
//                the MIPS subset (ADD/SUB/AND/OR, ADDI, BNE, LW, SW). One
//                instruction in flight: FETCH -> DECODE -> EXEC -> [MEM] ->
//                [WB] -> FETCH, with unsupported words diverted to TRAP.
//  Ports       : clk, rst (async, active-high)
//                bus_io (x_ctrl_fsm_if.master): fetch handshake, zero and
//                mem_ack status in; alu_op/reg_dst/alu_src selects,
//                reg_write/mem_read/mem_write/pc_write/pc_src/illegal strobes
//                and retired_count out.
//  Config      : X_CTRL_PERF_EN - when defined, retired_count counts retire
//                cycles; otherwise it is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module x_ctrl_fsm (
   input wire             clk,
   input wire             rst,
   x_ctrl_fsm_if.master   bus_io
);

   // ALU op encodings shared with X
   localparam logic [1:0] C_ALU_RTYPE = 2'b00;
   localparam logic [1:0] C_ALU_ADDI  = 2'b01;
   localparam logic [1:0] C_ALU_BRCMP = 2'b10;

   localparam logic [5:0] C_OP_RTYPE = 6'h00;
   localparam logic [5:0] C_OP_ADDI  = 6'h08;
   localparam logic [5:0] C_OP_BNE   = 6'h05;
   localparam logic [5:0] C_OP_LW    = 6'h23;
   localparam logic [5:0] C_OP_SW    = 6'h2B;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] ir_q, ir_d;

   // ------------------------------------------------------------------
   // Decode of the latched IR
   // ------------------------------------------------------------------
   logic [5:0] w_opcode;
   logic [5:0] w_funct;
   logic       w_is_r;
   logic       w_is_addi;
   logic       w_is_bne;
   logic       w_is_lw;
   logic       w_is_sw;
   logic       w_legal;

   assign w_opcode  = ir_q[31:26];
   assign w_funct   = ir_q[5:0];
   assign w_is_r    = (w_opcode == C_OP_RTYPE) &&
                      ((w_funct == 6'h20) || (w_funct == 6'h22) ||
                       (w_funct == 6'h24) || (w_funct == 6'h25));
   assign w_is_addi = (w_opcode == C_OP_ADDI);
   assign w_is_bne  = (w_opcode == C_OP_BNE);
   assign w_is_lw   = (w_opcode == C_OP_LW);
   assign w_is_sw   = (w_opcode == C_OP_SW);
   assign w_legal   = w_is_r | w_is_addi | w_is_bne | w_is_lw | w_is_sw;

   // Register fields are consumed by the datapath, not by the controller.
   logic w_unused_ir;
   assign w_unused_ir = &{1'b0, ir_q[25:6]};

   // ------------------------------------------------------------------
   // State and IR registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         ir_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and outputs
   // ------------------------------------------------------------------
   logic       w_instr_ready;
   logic [1:0] w_alu_op;
   logic       w_reg_dst;
   logic       w_alu_src;
   logic       w_reg_write;
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_pc_write;
   logic       w_pc_src;
   logic       w_illegal;

   always_comb begin
      state_d       = state_q;
      ir_d          = ir_q;
      w_instr_ready = 1'b0;
      w_alu_op      = C_ALU_RTYPE;
      w_reg_dst     = 1'b0;
      w_alu_src     = 1'b0;
      w_reg_write   = 1'b0;
      w_mem_read    = 1'b0;
      w_mem_write   = 1'b0;
      w_pc_write    = 1'b0;
      w_pc_src      = 1'b0;
      w_illegal     = 1'b0;

      case (state_q)
         S_FETCH: begin
            w_instr_ready = 1'b1;
            if (bus_io.instr_valid) begin
               ir_d    = bus_io.instr;
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            state_d = w_legal ? S_EXEC : S_TRAP;
         end

         S_EXEC: begin
            if (w_is_r) begin
               w_alu_op  = C_ALU_RTYPE;
               w_reg_dst = 1'b1;
               state_d   = S_WB;
            end else if (w_is_bne) begin
               // Branch resolves here: take it when the operands differ.
               w_alu_op   = C_ALU_BRCMP;
               w_pc_write = 1'b1;
               w_pc_src   = ~bus_io.zero;
               state_d    = S_FETCH;
            end else begin
               w_alu_op  = C_ALU_ADDI;
               w_alu_src = 1'b1;
               state_d   = w_is_addi ? S_WB : S_MEM;
            end
         end

         S_MEM: begin
            // Only LW/SW reach MEM; EXEC selects stay stable for the address.
            w_alu_op    = C_ALU_ADDI;
            w_alu_src   = 1'b1;
            w_mem_read  = w_is_lw;
            w_mem_write = ~w_is_lw;
            if (bus_io.mem_ack) begin
               if (w_is_lw) begin
                  state_d = S_WB;
               end else begin
                  w_pc_write = 1'b1;
                  state_d    = S_FETCH;
               end
            end
         end

         S_WB: begin
            w_reg_write = 1'b1;
            w_pc_write  = 1'b1;
            if (w_is_r) begin
               w_alu_op  = C_ALU_RTYPE;
               w_reg_dst = 1'b1;
            end else begin
               w_alu_op  = C_ALU_ADDI;
               w_alu_src = 1'b1;
            end
            state_d = S_FETCH;
         end

         S_TRAP: begin
            // Skip the offending word so fetch makes forward progress.
            w_illegal  = 1'b1;
            w_pc_write = 1'b1;
            state_d    = S_FETCH;
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   assign bus_io.instr_ready = w_instr_ready;
   assign bus_io.alu_op      = w_alu_op;
   assign bus_io.reg_dst     = w_reg_dst;
   assign bus_io.alu_src     = w_alu_src;
   assign bus_io.reg_write   = w_reg_write;
   assign bus_io.mem_read    = w_mem_read;
   assign bus_io.mem_write   = w_mem_write;
   assign bus_io.pc_write    = w_pc_write;
   assign bus_io.pc_src      = w_pc_src;
   assign bus_io.illegal     = w_illegal;

   // ------------------------------------------------------------------
   // Retired-instruction counter
   // ------------------------------------------------------------------
`ifdef X_CTRL_PERF_EN
   logic        w_retire;
   logic [31:0] retired_q;

   // Retire points: WB, BNE in EXEC, SW acknowledged in MEM. TRAP is excluded.
   assign w_retire = (state_q == S_WB) ||
                     ((state_q == S_EXEC) && w_is_bne) ||
                     ((state_q == S_MEM) && w_is_sw && bus_io.mem_ack);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired_q <= 32'd0;
      end else if (w_retire) begin
         retired_q <= retired_q + 32'd1;
      end
   end

   assign bus_io.retired_count = retired_q;
`else
   assign bus_io.retired_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_x_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_x_ctrl_fsm
//  Description : Directed self-checking bench for x_ctrl_fsm. Each scenario
//                task drives one instruction sequence cycle by cycle and
//                compares a packed snapshot of all control outputs against
//                hand-derived per-cycle expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_x_ctrl_fsm;

   logic clk;
   logic rst;

   x_ctrl_fsm_if bus ();

   x_ctrl_fsm u_dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fails = 0;
   logic [31:0] ret_model = 32'd0;

   // Snapshot layout: {ready, alu_op[1:0], reg_dst, alu_src,
   //                   reg_write, mem_read, mem_write, pc_write, pc_src, illegal}
   logic [10:0] obs;
   assign obs = {bus.instr_ready, bus.alu_op, bus.reg_dst, bus.alu_src,
                 bus.reg_write, bus.mem_read, bus.mem_write,
                 bus.pc_write, bus.pc_src, bus.illegal};

   localparam logic [10:0] V_FETCH = 11'b1_00_0_0_0_0_0_0_0_0;
   localparam logic [10:0] V_DEC   = 11'b0_00_0_0_0_0_0_0_0_0;
   localparam logic [10:0] V_EX_R  = 11'b0_00_1_0_0_0_0_0_0_0;
   localparam logic [10:0] V_WB_R  = 11'b0_00_1_0_1_0_0_1_0_0;
   localparam logic [10:0] V_EX_I  = 11'b0_01_0_1_0_0_0_0_0_0;
   localparam logic [10:0] V_WB_I  = 11'b0_01_0_1_1_0_0_1_0_0;
   localparam logic [10:0] V_BNE_Z = 11'b0_10_0_0_0_0_0_1_0_0;
   localparam logic [10:0] V_BNE_N = 11'b0_10_0_0_0_0_0_1_1_0;
   localparam logic [10:0] V_MEM_R = 11'b0_01_0_1_0_1_0_0_0_0;
   localparam logic [10:0] V_SW_AK = 11'b0_01_0_1_0_0_1_1_0_0;
   localparam logic [10:0] V_TRAP  = 11'b0_00_0_0_0_0_0_1_0_1;

   localparam logic [31:0] I_ADD  = 32'h0085_2020;
   localparam logic [31:0] I_ADDI = 32'h2085_0004;
   localparam logic [31:0] I_BNE  = 32'h1485_0003;
   localparam logic [31:0] I_LW   = 32'h8C85_0010;
   localparam logic [31:0] I_SW   = 32'hAC85_0010;
   localparam logic [31:0] I_OP3F = 32'hFC85_0000;
   localparam logic [31:0] I_NOR  = 32'h0085_2027;

   function automatic logic [31:0] exp_retired();
`ifdef X_CTRL_PERF_EN
      return ret_model;
`else
      return 32'd0;
`endif
   endfunction

   // ------------------------------------------------------------------
   task automatic test_reset();
      #1;
      n_tests++;
      if (obs !== V_FETCH) begin
         $display("FAIL reset_outputs got=%b exp=%b", obs, V_FETCH);
         n_fails++;
      end
      n_tests++;
      if (bus.retired_count !== 32'd0) begin
         $display("FAIL reset_retired got=%0d exp=0", bus.retired_count);
         n_fails++;
      end
      @(posedge clk); #1;
   endtask

   // ADD with instr_valid held high through the whole instruction.
   task automatic test_add();
      logic [10:0] exp [4];
      exp = '{V_FETCH, V_DEC, V_EX_R, V_WB_R};
      for (int c = 0; c < 4; c++) begin
         bus.instr_valid = 1'b1;
         bus.instr       = I_ADD;
         bus.zero        = 1'b0;
         bus.mem_ack     = 1'b0;
         #1;
         n_tests++;
         if (obs !== exp[c]) begin
            $display("FAIL add cyc=%0d got=%b exp=%b", c, obs, exp[c]);
            n_fails++;
         end
         @(posedge clk); #1;
      end
      ret_model = ret_model + 32'd1;
      n_tests++;
      if (bus.retired_count !== exp_retired()) begin
         $display("FAIL add_retired got=%0d exp=%0d", bus.retired_count, exp_retired());
         n_fails++;
      end
   endtask

   // ADDI, then BNE zero=1, then BNE zero=0, each issued right after retire.
   task automatic test_addi_bne();
      logic [10:0] exp [10];
      logic [31:0] wrd [10];
      logic [9:0]  vld;
      logic [9:0]  zro;
      exp = '{V_FETCH, V_DEC, V_EX_I, V_WB_I,
              V_FETCH, V_DEC, V_BNE_Z,
              V_FETCH, V_DEC, V_BNE_N};
      wrd = '{I_ADDI, I_ADDI, I_ADDI, I_ADDI,
              I_BNE, I_BNE, I_BNE, I_BNE, I_BNE, I_BNE};
      vld = 10'b00_1001_0001;
      zro = 10'b00_0111_0000;
      for (int c = 0; c < 10; c++) begin
         bus.instr_valid = vld[c];
         bus.instr       = wrd[c];
         bus.zero        = zro[c];
         bus.mem_ack     = 1'b0;
         #1;
         n_tests++;
         if (obs !== exp[c]) begin
            $display("FAIL addi_bne cyc=%0d got=%b exp=%b", c, obs, exp[c]);
            n_fails++;
         end
         @(posedge clk); #1;
      end
      ret_model = ret_model + 32'd3;
      n_tests++;
      if (bus.retired_count !== exp_retired()) begin
         $display("FAIL addi_bne_retired got=%0d exp=%0d", bus.retired_count, exp_retired());
         n_fails++;
      end
   endtask

   // LW with mem_ack low for 3 MEM cycles; a stray ack in EXEC is ignored.
   task automatic test_lw();
      logic [10:0] exp [8];
      logic [7:0]  ack;
      int          rd_cycles;
      exp = '{V_FETCH, V_DEC, V_EX_I, V_MEM_R, V_MEM_R, V_MEM_R, V_MEM_R, V_WB_I};
      ack = 8'b0100_0100;
      rd_cycles = 0;
      for (int c = 0; c < 8; c++) begin
         bus.instr_valid = (c == 0);
         bus.instr       = I_LW;
         bus.zero        = 1'b0;
         bus.mem_ack     = ack[c];
         #1;
         if (bus.mem_read === 1'b1) rd_cycles++;
         n_tests++;
         if (obs !== exp[c]) begin
            $display("FAIL lw cyc=%0d got=%b exp=%b", c, obs, exp[c]);
            n_fails++;
         end
         @(posedge clk); #1;
      end
      n_tests++;
      if (rd_cycles != 4) begin
         $display("FAIL lw_read_len got=%0d exp=4", rd_cycles);
         n_fails++;
      end
      ret_model = ret_model + 32'd1;
      n_tests++;
      if (bus.retired_count !== exp_retired()) begin
         $display("FAIL lw_retired got=%0d exp=%0d", bus.retired_count, exp_retired());
         n_fails++;
      end
   endtask

   // SW acked on the first MEM cycle; mem_ack held high throughout.
   task automatic test_sw();
      logic [10:0] exp [4];
      exp = '{V_FETCH, V_DEC, V_EX_I, V_SW_AK};
      for (int c = 0; c < 4; c++) begin
         bus.instr_valid = (c == 0);
         bus.instr       = I_SW;
         bus.zero        = 1'b0;
         bus.mem_ack     = 1'b1;
         #1;
         n_tests++;
         if (obs !== exp[c]) begin
            $display("FAIL sw cyc=%0d got=%b exp=%b", c, obs, exp[c]);
            n_fails++;
         end
         @(posedge clk); #1;
      end
      bus.mem_ack = 1'b0;
      ret_model = ret_model + 32'd1;
      n_tests++;
      if (bus.retired_count !== exp_retired()) begin
         $display("FAIL sw_retired got=%0d exp=%0d", bus.retired_count, exp_retired());
         n_fails++;
      end
   endtask

   // Opcode 0x3F then R-type funct 0x27: both trap, neither retires.
   task automatic test_illegal();
      logic [10:0] exp [6];
      logic [31:0] wrd [6];
      exp = '{V_FETCH, V_DEC, V_TRAP, V_FETCH, V_DEC, V_TRAP};
      wrd = '{I_OP3F, I_OP3F, I_OP3F, I_NOR, I_NOR, I_NOR};
      for (int c = 0; c < 6; c++) begin
         bus.instr_valid = (c == 0) || (c == 3);
         bus.instr       = wrd[c];
         bus.zero        = 1'b0;
         bus.mem_ack     = 1'b0;
         #1;
         n_tests++;
         if (obs !== exp[c]) begin
            $display("FAIL illegal cyc=%0d got=%b exp=%b", c, obs, exp[c]);
            n_fails++;
         end
         @(posedge clk); #1;
      end
      n_tests++;
      if (bus.retired_count !== exp_retired()) begin
         $display("FAIL illegal_retired got=%0d exp=%0d", bus.retired_count, exp_retired());
         n_fails++;
      end
   endtask

   // Reset pulsed mid-cycle while LW waits in MEM.
   task automatic test_reset_mid();
      logic [10:0] exp [4];
      exp = '{V_FETCH, V_DEC, V_EX_I, V_MEM_R};
      for (int c = 0; c < 4; c++) begin
         bus.instr_valid = (c == 0);
         bus.instr       = I_LW;
         bus.zero        = 1'b0;
         bus.mem_ack     = 1'b0;
         #1;
         n_tests++;
         if (obs !== exp[c]) begin
            $display("FAIL rst_mid_pre cyc=%0d got=%b exp=%b", c, obs, exp[c]);
            n_fails++;
         end
         if (c < 3) begin
            @(posedge clk); #1;
         end
      end
      #2;
      rst = 1'b1;
      ret_model = 32'd0;
      #1;
      n_tests++;
      if (obs !== V_FETCH) begin
         $display("FAIL rst_mid_async got=%b exp=%b", obs, V_FETCH);
         n_fails++;
      end
      n_tests++;
      if (bus.retired_count !== 32'd0) begin
         $display("FAIL rst_mid_retired got=%0d exp=0", bus.retired_count);
         n_fails++;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.mem_ack = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++;
         if (obs !== V_FETCH) begin
            $display("FAIL rst_mid_post cyc=%0d got=%b exp=%b", c, obs, V_FETCH);
            n_fails++;
         end
         @(posedge clk); #1;
      end
      bus.mem_ack = 1'b0;
   endtask

   initial begin
      rst             = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = 32'd0;
      bus.zero        = 1'b0;
      bus.mem_ack     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      test_reset();
      test_add();
      test_addi_bne();
      test_lw();
      test_sw();
      test_illegal();
      test_reset_mid();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
